renkon_wload: RTL and testbench

- Parametrised weight/bias distribution engine for the renkon convolution array.
- Takes one valid/ready word stream in the host layer order and writes it into CORE per-core network memories using the existing net_we/net_addr/write_net bank-write convention.
- Core count, data width, memory depth and filter size are generalised.
- New behaviour: automatic zero-fill of unused cores in a remainder group, a base-address offset, and stream back-pressure.

---
 rtl/renkon_wload.sv | 143 ++++++++++++++
 tb/tb_renkon_wload.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/renkon_wload.sv
// renkon_wload: distributes a weight/bias word stream into CORE network memories,
// one group of CORE cores at a time. Cores past n_out in the last group are zero-filled.
module renkon_wload #(
    parameter int CORE    = 8,
    parameter int CORELOG = $clog2(CORE),
    parameter int DWIDTH  = 16,
    parameter int NETSIZE = 11,
    parameter int LWIDTH  = 10
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               req,
    input  logic [LWIDTH-1:0]  n_in,
    input  logic [LWIDTH-1:0]  n_out,
    input  logic [LWIDTH-1:0]  fil_size,
    input  logic [NETSIZE-1:0] net_base,
    input  logic               s_valid,
    input  logic [DWIDTH-1:0]  s_data,
    output logic               s_ready,
    output logic [CORELOG:0]   net_we,
    output logic [NETSIZE-1:0] net_addr,
    output logic [DWIDTH-1:0]  write_net,
    output logic               busy,
    output logic               ack
);
    localparam int WW = 3*LWIDTH + 1;        // words per core block
    localparam int MW = LWIDTH + CORELOG + 1; // flat core index CORE*g+j

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [LWIDTH-1:0]  n_out_q, n_out_d;
    logic [WW-1:0]      wlen_q, wlen_d, w_q, w_d;
    logic [CORELOG-1:0] j_q, j_d;
    logic [MW-1:0]      map_q, map_d;
    logic [NETSIZE-1:0] gbase_q, gbase_d;
    logic [CORELOG:0]   we_q, we_d;
    logic [NETSIZE-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0]  data_q, data_d;
    logic               busy_q, busy_d, ack_q, ack_d;
    logic [2*LWIDTH-1:0] f2;
    logic               live, step, wlast, jlast, glast;

    assign f2    = {{LWIDTH{1'b0}}, fil_size} * {{LWIDTH{1'b0}}, fil_size};
    assign live  = (map_q < MW'(n_out_q));
    assign wlast = (w_q == wlen_q - WW'(1));
    assign jlast = (j_q == CORELOG'(CORE-1));
    // Only meaningful when jlast: the group just finished covers all of n_out.
    assign glast = ((map_q + MW'(1)) >= MW'(n_out_q));
    assign step  = (state_q == RUN) && (!live || s_valid);
    assign s_ready = (state_q == RUN) && live;

    always_comb begin
        state_d = state_q;
        n_out_d = n_out_q;
        wlen_d  = wlen_q;
        w_d     = w_q;
        j_d     = j_q;
        map_d   = map_q;
        gbase_d = gbase_q;
        we_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    n_out_d = n_out;
                    wlen_d  = WW'(n_in) * WW'(f2) + WW'(1);
                    gbase_d = net_base;
                    w_d     = '0;
                    j_d     = '0;
                    map_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (n_out != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (step) begin
                    we_d   = {1'b0, j_q} + (CORELOG+1)'(1);
                    addr_d = gbase_q + NETSIZE'(w_q);
                    data_d = live ? s_data : '0;
                    if (wlast) begin
                        w_d   = '0;
                        map_d = map_q + MW'(1);
                        if (jlast) begin
                            j_d     = '0;
                            gbase_d = gbase_q + NETSIZE'(wlen_q);
                            if (glast) state_d = DONE;
                        end else begin
                            j_d = j_q + CORELOG'(1);
                        end
                    end else begin
                        w_d = w_q + WW'(1);
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= IDLE;
            n_out_q <= '0;
            wlen_q  <= '0;
            w_q     <= '0;
            j_q     <= '0;
            map_q   <= '0;
            gbase_q <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_out_q <= n_out_d;
            wlen_q  <= wlen_d;
            w_q     <= w_d;
            j_q     <= j_d;
            map_q   <= map_d;
            gbase_q <= gbase_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign net_we    = we_q;
    assign net_addr  = addr_q;
    assign write_net = data_q;
    assign busy      = busy_q;
    assign ack       = ack_q;
endmodule

// File: tb/tb_renkon_wload.sv
// Directed bench for renkon_wload with CORE=4: full load, remainder zero-fill,
// back-pressure, empty/degenerate shapes, address wrap and mid-load reset.
module tb_renkon_wload;
    localparam int CORE = 4, CL = 2, DW = 16, NS = 11, LW = 10;

    logic          clk = 1'b0, xrst = 1'b0, req = 1'b0, s_valid = 1'b0;
    logic [LW-1:0] n_in = '0, n_out = '0, fil_size = '0;
    logic [NS-1:0] net_base = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, busy, ack;
    logic [CL:0]   net_we;
    logic [NS-1:0] net_addr;
    logic [DW-1:0] write_net;

    int errors = 0, checks = 0, cyc = 0;
    int wcore[$], waddr[$], wdata[$], wcyc[$], hcyc[$];
    int ecore[$], eaddr[$], edata[$];
    int ack_cnt = 0, ack_cyc = 0, req_cyc = 0, consumed = 0;
    bit rdy_seen = 1'b0;

    renkon_wload #(.CORE(CORE), .DWIDTH(DW), .NETSIZE(NS), .LWIDTH(LW)) dut (
        .clk(clk), .xrst(xrst), .req(req), .n_in(n_in), .n_out(n_out),
        .fil_size(fil_size), .net_base(net_base), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .net_we(net_we), .net_addr(net_addr), .write_net(write_net),
        .busy(busy), .ack(ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (net_we != 0) begin
            wcore.push_back(int'(net_we));
            waddr.push_back(int'(net_addr));
            wdata.push_back(int'(write_net));
            wcyc.push_back(cyc);
        end
        if (ack) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
    end

    // Reference write sequence: stream word k carries value 0x1000+k.
    task automatic build_exp(input int ni, input int f, input int no, input int base);
        int w, g, k;
        w = ni*f*f + 1;
        g = (no + CORE - 1) / CORE;
        k = 0;
        ecore.delete(); eaddr.delete(); edata.delete();
        for (int gi = 0; gi < g; gi++)
            for (int j = 0; j < CORE; j++)
                for (int x = 0; x < w; x++) begin
                    ecore.push_back(j + 1);
                    eaddr.push_back((base + gi*w + x) % 2048);
                    if (CORE*gi + j < no) begin
                        edata.push_back(32'h1000 + k);
                        k++;
                    end else edata.push_back(0);
                end
    endtask

    task automatic run_load(input int ni, input int f, input int no, input int base,
                            input bit rnd, input int abort_at, input bit poke);
        int k, t;
        bit done;
        k = 0; t = 0; done = 1'b0;
        wcore.delete(); waddr.delete(); wdata.delete(); wcyc.delete(); hcyc.delete();
        ack_cnt = 0; rdy_seen = 1'b0;
        @(negedge clk); #1;
        req = 1'b1; n_in = LW'(ni); fil_size = LW'(f); n_out = LW'(no); net_base = NS'(base);
        req_cyc = cyc;
        @(negedge clk); #1;
        req = 1'b0; n_in = 7; fil_size = 5; n_out = 9; net_base = 100;
        while (!done) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = DW'(32'h1000 + k);
            if (s_ready) rdy_seen = 1'b1;
            if (s_valid && s_ready) begin
                hcyc.push_back(cyc);
                k++;
            end
            req = (poke && wcore.size() == 10);
            @(negedge clk); #1;
            t++;
            if (ack_cnt > 0) done = 1'b1;
            if (abort_at > 0 && wcore.size() >= abort_at) begin
                xrst = 1'b0;
                done = 1'b1;
            end
            if (t > 3000) begin
                checks++; errors++;
                $display("FAIL timeout no ack within 3000 cycles");
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
        req = 1'b0;
        consumed = k;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({net_we, net_addr, write_net, busy, ack, s_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%0d addr=%0d data=%h busy=%b ack=%b rdy=%b want all 0",
                     net_we, net_addr, write_net, busy, ack, s_ready);
        end
        #1 xrst = 1'b1;
    endtask

    task automatic test_full();
        run_load(2, 3, 4, 0, 1'b0, 0, 1'b1);
        build_exp(2, 3, 4, 0);
        checks++;
        if (wcore.size() !== 76) begin errors++; $display("FAIL full_count got %0d want 76", wcore.size()); end
        for (int i = 0; i < ecore.size(); i++) begin
            checks++;
            if (i >= wcore.size() || wcore[i] !== ecore[i] || waddr[i] !== eaddr[i] || wdata[i] !== edata[i]) begin
                errors++;
                if (errors < 10) $display("FAIL full_word%0d got core=%0d addr=%0d data=%h want core=%0d addr=%0d data=%h",
                                          i, wcore[i], waddr[i], wdata[i], ecore[i], eaddr[i], edata[i]);
            end
        end
        checks++;
        if (wcore[18] !== 1 || waddr[18] !== 18 || wdata[18] !== 32'h1012) begin
            errors++; $display("FAIL full_bias0 got core=%0d addr=%0d data=%h want 1 18 1012", wcore[18], waddr[18], wdata[18]);
        end
        checks++;
        if (wcore[75] !== 4 || waddr[75] !== 18 || wdata[75] !== 32'h104b) begin
            errors++; $display("FAIL full_bias3 got core=%0d addr=%0d data=%h want 4 18 104b", wcore[75], waddr[75], wdata[75]);
        end
        checks++;
        if (wcyc[0] - req_cyc !== 2) begin errors++; $display("FAIL full_latency got %0d want 2", wcyc[0] - req_cyc); end
        checks++;
        if (wcyc[75] - wcyc[0] !== 75) begin errors++; $display("FAIL full_contig got %0d want 75", wcyc[75] - wcyc[0]); end
        checks++;
        if (ack_cyc !== wcyc[75] + 1 || ack_cnt !== 1) begin
            errors++; $display("FAIL full_ack got cyc=%0d cnt=%0d want cyc=%0d cnt=1", ack_cyc, ack_cnt, wcyc[75] + 1);
        end
        checks++;
        if (busy !== 1'b0 || consumed !== 76) begin
            errors++; $display("FAIL full_busy_consumed got busy=%b words=%0d want 0 76", busy, consumed);
        end
    endtask

    task automatic test_remainder();
        run_load(2, 3, 6, 0, 1'b0, 0, 1'b0);
        build_exp(2, 3, 6, 0);
        checks++;
        if (wcore.size() !== 152 || consumed !== 114) begin
            errors++; $display("FAIL rem_count got writes=%0d words=%0d want 152 114", wcore.size(), consumed);
        end
        for (int i = 0; i < ecore.size(); i++) begin
            checks++;
            if (i >= wcore.size() || wcore[i] !== ecore[i] || waddr[i] !== eaddr[i] || wdata[i] !== edata[i]) begin
                errors++;
                if (errors < 10) $display("FAIL rem_word%0d got core=%0d addr=%0d data=%h want core=%0d addr=%0d data=%h",
                                          i, wcore[i], waddr[i], wdata[i], ecore[i], eaddr[i], edata[i]);
            end
        end
        checks++;
        if (wcore[94] !== 1 || waddr[94] !== 37 || wdata[94] !== 32'h105e) begin
            errors++; $display("FAIL rem_g1c0_bias got core=%0d addr=%0d data=%h want 1 37 105e", wcore[94], waddr[94], wdata[94]);
        end
        checks++;
        if (wcore[114] !== 3 || waddr[114] !== 19 || wdata[114] !== 0) begin
            errors++; $display("FAIL rem_dead got core=%0d addr=%0d data=%h want 3 19 0", wcore[114], waddr[114], wdata[114]);
        end
    endtask

    task automatic test_backpressure();
        run_load(2, 3, 4, 0, 1'b1, 0, 1'b0);
        build_exp(2, 3, 4, 0);
        checks++;
        if (wcore.size() !== 76 || hcyc.size() !== 76) begin
            errors++; $display("FAIL bp_count got writes=%0d words=%0d want 76 76", wcore.size(), hcyc.size());
        end
        for (int i = 0; i < ecore.size(); i++) begin
            checks++;
            if (i >= wcore.size() || i >= hcyc.size() || wcore[i] !== ecore[i] || waddr[i] !== eaddr[i] ||
                wdata[i] !== edata[i] || wcyc[i] !== hcyc[i] + 1) begin
                errors++;
                if (errors < 10) $display("FAIL bp_word%0d got core=%0d addr=%0d data=%h cyc=%0d want core=%0d addr=%0d data=%h cyc=%0d",
                                          i, wcore[i], waddr[i], wdata[i], wcyc[i], ecore[i], eaddr[i], edata[i], hcyc[i] + 1);
            end
        end
    endtask

    task automatic test_zero_shapes();
        run_load(2, 3, 0, 0, 1'b0, 0, 1'b0);
        checks++;
        if (wcore.size() !== 0 || rdy_seen !== 1'b0 || consumed !== 0) begin
            errors++; $display("FAIL nout0_quiet got writes=%0d ready=%b words=%0d want 0 0 0", wcore.size(), rdy_seen, consumed);
        end
        checks++;
        if (ack_cyc - req_cyc !== 2) begin errors++; $display("FAIL nout0_ack got %0d want 2", ack_cyc - req_cyc); end
        run_load(0, 3, 4, 5, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wcore.size() || wcore[i] !== i + 1 || waddr[i] !== 5 || wdata[i] !== 32'h1000 + i) begin
                errors++; $display("FAIL nin0_word%0d got core=%0d addr=%0d data=%h want core=%0d addr=5 data=%h",
                                   i, wcore[i], waddr[i], wdata[i], i + 1, 32'h1000 + i);
            end
        end
        run_load(2, 0, 4, 5, 1'b0, 0, 1'b0);
        checks++;
        if (wcore.size() !== 4 || waddr[3] !== 5 || wcore[3] !== 4 || wdata[3] !== 32'h1003) begin
            errors++; $display("FAIL f0 got writes=%0d core=%0d addr=%0d data=%h want 4 4 5 1003",
                               wcore.size(), wcore[3], waddr[3], wdata[3]);
        end
    endtask

    task automatic test_wrap();
        run_load(1, 3, 1, 2040, 1'b0, 0, 1'b0);
        build_exp(1, 3, 1, 2040);
        checks++;
        if (wcore.size() !== 40) begin errors++; $display("FAIL wrap_count got %0d want 40", wcore.size()); end
        for (int i = 0; i < ecore.size(); i++) begin
            checks++;
            if (i >= wcore.size() || wcore[i] !== ecore[i] || waddr[i] !== eaddr[i] || wdata[i] !== edata[i]) begin
                errors++;
                if (errors < 10) $display("FAIL wrap_word%0d got core=%0d addr=%0d data=%h want core=%0d addr=%0d data=%h",
                                          i, wcore[i], waddr[i], wdata[i], ecore[i], eaddr[i], edata[i]);
            end
        end
        checks++;
        if (waddr[7] !== 2047 || waddr[8] !== 0 || waddr[9] !== 1 || wdata[9] !== 32'h1009) begin
            errors++; $display("FAIL wrap_edge got %0d %0d %0d data=%h want 2047 0 1 1009", waddr[7], waddr[8], waddr[9], wdata[9]);
        end
        checks++;
        if (wcore[10] !== 2 || waddr[10] !== 2040 || wdata[10] !== 0) begin
            errors++; $display("FAIL wrap_core1 got core=%0d addr=%0d data=%h want 2 2040 0", wcore[10], waddr[10], wdata[10]);
        end
    endtask

    task automatic test_xrst_midload();
        run_load(2, 3, 4, 0, 1'b0, 30, 1'b0);
        #1;
        checks++;
        if ({net_we, net_addr, write_net, busy, ack, s_ready} !== '0 || wcore.size() !== 30) begin
            errors++; $display("FAIL xrst_clear got we=%0d addr=%0d busy=%b rdy=%b writes=%0d want 0 0 0 0 30",
                               net_we, net_addr, busy, s_ready, wcore.size());
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || net_we !== '0) begin
            errors++; $display("FAIL xrst_hold got busy=%b rdy=%b we=%0d want 0 0 0", busy, s_ready, net_we);
        end
        #1 xrst = 1'b1;
        run_load(2, 3, 4, 0, 1'b0, 0, 1'b0);
        build_exp(2, 3, 4, 0);
        checks++;
        if (wcore.size() !== 76 || ack_cnt !== 1) begin
            errors++; $display("FAIL xrst_rerun got writes=%0d acks=%0d want 76 1", wcore.size(), ack_cnt);
        end
        for (int i = 0; i < ecore.size(); i++) begin
            checks++;
            if (i >= wcore.size() || wcore[i] !== ecore[i] || waddr[i] !== eaddr[i] || wdata[i] !== edata[i]) begin
                errors++;
                if (errors < 10) $display("FAIL xrst_word%0d got core=%0d addr=%0d data=%h want core=%0d addr=%0d data=%h",
                                          i, wcore[i], waddr[i], wdata[i], ecore[i], eaddr[i], edata[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_remainder();
        test_backpressure();
        test_zero_shapes();
        test_wrap();
        test_xrst_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
